// File: rtl/seq_detector_pkg.sv
// -----------------------------------------------------------------------------
// seq_det_pkg
// Shared constants and types for the serial pattern detector.
//   SEQ_DET_PAT_LEN_DEF  default pattern length in bits
//   SEQ_DET_CNT_W_DEF    default match counter width
//   SEQ_DET_RST_PATTERN  pattern register value after reset (zero-extended)
//   seq_mode_e           detection mode selected by the overlap input
// -----------------------------------------------------------------------------
package seq_det_pkg;

    localparam int         SEQ_DET_PAT_LEN_DEF = 4;
    localparam int         SEQ_DET_CNT_W_DEF   = 8;
    localparam logic [3:0] SEQ_DET_RST_PATTERN = 4'b1101;

    typedef enum logic {
        SEQ_NONOVERLAP = 1'b0,
        SEQ_OVERLAP    = 1'b1
    } seq_mode_e;

endpackage : seq_det_pkg

// File: rtl/seq_detector_if.sv
// -----------------------------------------------------------------------------
// seq_detector_if
// Bundles the data/control/status signals of seq_detector.
//   x_valid, x      qualified serial input bit
//   pattern_in      new pattern (bit PAT_LEN-1 is the oldest bit)
//   pattern_load    load pattern_in, restart history
//   overlap         1 = overlapping detection, 0 = non-overlapping
//   count_clr       clear the match counter
//   z               registered match pulse
//   match_count     saturating match count
//   pattern         current pattern register
//   z_early         combinational match (only with SEQ_DETECTOR_EARLY_Z_EN)
// Modports: master drives the inputs, slave is the detector.
// -----------------------------------------------------------------------------
interface seq_detector_if
    import seq_det_pkg::*;
#(
    parameter int PAT_LEN = SEQ_DET_PAT_LEN_DEF,
    parameter int CNT_W   = SEQ_DET_CNT_W_DEF
);

    logic               x_valid;
    logic               x;
    logic [PAT_LEN-1:0] pattern_in;
    logic               pattern_load;
    logic               overlap;
    logic               count_clr;
    logic               z;
    logic [CNT_W-1:0]   match_count;
    logic [PAT_LEN-1:0] pattern;
`ifdef SEQ_DETECTOR_EARLY_Z_EN
    logic               z_early;
`endif

`ifdef SEQ_DETECTOR_EARLY_Z_EN
    modport master (
        output x_valid, x, pattern_in, pattern_load, overlap, count_clr,
        input  z, match_count, pattern, z_early
    );

    modport slave (
        input  x_valid, x, pattern_in, pattern_load, overlap, count_clr,
        output z, match_count, pattern, z_early
    );
`else
    modport master (
        output x_valid, x, pattern_in, pattern_load, overlap, count_clr,
        input  z, match_count, pattern
    );

    modport slave (
        input  x_valid, x, pattern_in, pattern_load, overlap, count_clr,
        output z, match_count, pattern
    );
`endif

endinterface : seq_detector_if

// File: rtl/seq_detector_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// W-bit registered up-counter that saturates at all-ones.
//   clk    clock
//   reset  synchronous, active-high; clears the count
//   clr    clear request
//   inc    increment request
//   count  current count
// clr together with inc yields 1, so an event on the clearing edge is kept.
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
    localparam logic [W-1:0] CNT_ONE = W'(1);

    logic [W-1:0] count_r;
    logic [W-1:0] count_next_s;

    // Next count: clear has priority, increment stops at all-ones.
    always_comb begin
        count_next_s = count_r;
        if (clr && inc) begin
            count_next_s = CNT_ONE;
        end else if (clr) begin
            count_next_s = {W{1'b0}};
        end else if (inc && (count_r != CNT_MAX)) begin
            count_next_s = count_r + CNT_ONE;
        end else begin
            count_next_s = count_r;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {W{1'b0}};
        end else begin
            count_r <= count_next_s;
        end
    end

    assign count = count_r;

endmodule : sat_counter

// File: rtl/seq_detector.sv
// -----------------------------------------------------------------------------
// seq_detector
// Serial bit-pattern detector with runtime-loadable pattern of PAT_LEN bits.
// One qualified bit per cycle shifts into a history register; when the
// history equals the pattern and at least PAT_LEN bits have been collected,
// a one-cycle registered pulse z is produced and match_count increments.
//   clk          clock, rising edge
//   reset        synchronous, active-high; overrides every other input
//   bus (slave)  seq_detector_if: x_valid, x, pattern_in, pattern_load,
//                overlap, count_clr in; z, match_count, pattern out
// Optional macro SEQ_DETECTOR_EARLY_Z_EN adds bus.z_early, a combinational
// match output that leads z by one cycle.
// -----------------------------------------------------------------------------
module seq_detector
    import seq_det_pkg::*;
#(
    parameter int                 PAT_LEN     = SEQ_DET_PAT_LEN_DEF,
    parameter int                 CNT_W       = SEQ_DET_CNT_W_DEF,
    parameter logic [PAT_LEN-1:0] RST_PATTERN = PAT_LEN'(SEQ_DET_RST_PATTERN)
) (
    input  logic         clk,
    input  logic         reset,
    seq_detector_if.slave bus
);

    // fill counts 0..PAT_LEN inclusive.
    localparam int                FILL_W    = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_LEN - 1);
    localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);

    logic [PAT_LEN-1:0] hist_r;
    logic [FILL_W-1:0]  fill_r;
    logic [PAT_LEN-1:0] pattern_r;
    logic               z_r;

    logic [PAT_LEN-1:0] next_hist_s;
    logic [FILL_W-1:0]  fill_next_s;
    logic               accept_s;
    logic               match_s;
    seq_mode_e          mode_s;
    logic [CNT_W-1:0]   count_s;

    assign mode_s      = seq_mode_e'(bus.overlap);
    assign accept_s    = bus.x_valid & ~bus.pattern_load;
    assign next_hist_s = {hist_r[PAT_LEN-2:0], bus.x};
    // (fill+1) >= PAT_LEN is the same as fill >= PAT_LEN-1.
    assign match_s     = accept_s & (next_hist_s == pattern_r) & (fill_r >= FILL_LAST);

    // Next fill: a load restarts collection; in non-overlap mode a match
    // also restarts it so the next hit needs PAT_LEN fresh bits.
    always_comb begin
        fill_next_s = fill_r;
        if (bus.pattern_load) begin
            fill_next_s = {FILL_W{1'b0}};
        end else if (bus.x_valid) begin
            case (mode_s)
                SEQ_NONOVERLAP: begin
                    if (match_s) begin
                        fill_next_s = {FILL_W{1'b0}};
                    end else if (fill_r == FILL_FULL) begin
                        fill_next_s = fill_r;
                    end else begin
                        fill_next_s = fill_r + FILL_ONE;
                    end
                end
                SEQ_OVERLAP: begin
                    if (fill_r == FILL_FULL) begin
                        fill_next_s = fill_r;
                    end else begin
                        fill_next_s = fill_r + FILL_ONE;
                    end
                end
                default: fill_next_s = fill_r;
            endcase
        end else begin
            fill_next_s = fill_r;
        end
    end

    // History, fill, pattern and match pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            hist_r    <= {PAT_LEN{1'b0}};
            fill_r    <= {FILL_W{1'b0}};
            pattern_r <= RST_PATTERN;
            z_r       <= 1'b0;
        end else begin
            z_r    <= match_s;
            fill_r <= fill_next_s;
            if (bus.pattern_load) begin
                pattern_r <= bus.pattern_in;
                hist_r    <= {PAT_LEN{1'b0}};
            end else if (bus.x_valid) begin
                hist_r <= next_hist_s;
            end else begin
                hist_r <= hist_r;
            end
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (bus.count_clr),
        .inc   (match_s),
        .count (count_s)
    );

    assign bus.z           = z_r;
    assign bus.match_count = count_s;
    assign bus.pattern     = pattern_r;

`ifdef SEQ_DETECTOR_EARLY_Z_EN
    assign bus.z_early = match_s;
`endif

endmodule : seq_detector

// File: tb/tb_seq_detector.sv
// -----------------------------------------------------------------------------
// tb_seq_detector
// Drives two detectors (CNT_W=8 and CNT_W=2) with identical stimulus and
// compares them against a queue-based reference model: directed scenarios
// first, then a randomized stream.
// -----------------------------------------------------------------------------
module tb_seq_detector;
    import seq_det_pkg::*;

    localparam int PL = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    seq_detector_if #(.PAT_LEN(PL), .CNT_W(8)) bus_a ();
    seq_detector_if #(.PAT_LEN(PL), .CNT_W(2)) bus_b ();

    seq_detector #(.PAT_LEN(PL), .CNT_W(8)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    seq_detector #(.PAT_LEN(PL), .CNT_W(2)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: accepted bits since the last restart, newest at back.
    bit          hq[$];
    logic [3:0]  m_pat;
    int          m_cnt_a;
    int          m_cnt_b;
    bit          m_z;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_match(input bit v, input bit xb, input bit ld);
        bit tmp[$];
        int n;
        if (!v || ld) return 1'b0;
        tmp = hq;
        tmp.push_back(xb);
        n = tmp.size();
        if (n < PL) return 1'b0;
        for (int i = 0; i < PL; i++) begin
            if (tmp[n-1-i] != m_pat[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int sat_next(input int cnt, input int maxv, input bit m, input bit clr);
        if (clr) return m ? 1 : 0;
        if (m) return (cnt < maxv) ? cnt + 1 : maxv;
        return cnt;
    endfunction

    task automatic model_reset();
        hq.delete();
        m_pat   = SEQ_DET_RST_PATTERN;
        m_cnt_a = 0;
        m_cnt_b = 0;
        m_z     = 1'b0;
    endtask

    task automatic model_update(input bit m, input bit v, input bit xb, input bit ld,
                                input logic [3:0] pin, input bit ov, input bit clr);
        m_z     = m;
        m_cnt_a = sat_next(m_cnt_a, 255, m, clr);
        m_cnt_b = sat_next(m_cnt_b, 3, m, clr);
        if (ld) begin
            m_pat = pin;
            hq.delete();
        end else if (v) begin
            hq.push_back(xb);
            if (hq.size() > PL) void'(hq.pop_front());
            if (m && !ov) hq.delete();
        end
    endtask

    task automatic drive(input bit v, input bit xb, input bit ld, input logic [3:0] pin,
                         input bit ov, input bit clr);
        bus_a.x_valid = v;  bus_a.x = xb;  bus_a.pattern_load = ld;
        bus_a.pattern_in = pin;  bus_a.overlap = ov;  bus_a.count_clr = clr;
        bus_b.x_valid = v;  bus_b.x = xb;  bus_b.pattern_load = ld;
        bus_b.pattern_in = pin;  bus_b.overlap = ov;  bus_b.count_clr = clr;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".z_a"},   32'(bus_a.z),           32'(m_z));
        chk({tag, ".z_b"},   32'(bus_b.z),           32'(m_z));
        chk({tag, ".cnt_a"}, 32'(bus_a.match_count), 32'(m_cnt_a));
        chk({tag, ".cnt_b"}, 32'(bus_b.match_count), 32'(m_cnt_b));
        chk({tag, ".pat_a"}, 32'(bus_a.pattern),     32'(m_pat));
    endtask

    task automatic step(input bit v, input bit xb, input bit ld, input logic [3:0] pin,
                        input bit ov, input bit clr, input string tag);
        bit m;
        @(negedge clk);
        drive(v, xb, ld, pin, ov, clr);
        m = model_match(v, xb, ld);
        #1;
`ifdef SEQ_DETECTOR_EARLY_Z_EN
        chk({tag, ".z_early_a"}, 32'(bus_a.z_early), 32'(m));
        chk({tag, ".z_early_b"}, 32'(bus_b.z_early), 32'(m));
`endif
        @(posedge clk);
        #1;
        model_update(m, v, xb, ld, pin, ov, clr);
        check_outputs(tag);
    endtask

    task automatic do_reset(input bit v, input bit xb, input bit ld, input bit clr);
        @(negedge clk);
        reset = 1'b1;
        drive(v, xb, ld, 4'b0000, 1'b1, clr);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        check_outputs("reset");
    endtask

    initial begin
        bit s1[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        bit s4[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        bit ov_r;

        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);
        model_reset();

        // Reset state, with other inputs active to show reset overrides them.
        do_reset(1'b1, 1'b1, 1'b1, 1'b0);
        chk("rst_pattern", 32'(bus_a.pattern), 32'h0000_000d);

        // Overlapping detection of 1101 in 1101101.
        for (int i = 0; i < 7; i++) step(1'b1, s1[i], 1'b0, 4'b0000, 1'b1, 1'b0, "ovl");
        chk("ovl_count", 32'(bus_a.match_count), 32'd2);
        chk("ovl_z_last", 32'(bus_a.z), 32'd1);

        // Non-overlapping: only the first hit.
        do_reset(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b1, s1[i], 1'b0, 4'b0000, 1'b0, 1'b0, "novl");
        chk("novl_count", 32'(bus_a.match_count), 32'd1);
        chk("novl_z_last", 32'(bus_a.z), 32'd0);

        // Pattern load with a valid bit on the same cycle drops that bit.
        do_reset(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, "ld");
        step(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, "ld");
        step(1'b1, 1'b1, 1'b1, 4'b0110, 1'b1, 1'b0, "ld");
        step(1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, "ld");
        step(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, "ld");
        step(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, "ld");
        chk("ld_no_early", 32'(bus_a.match_count), 32'd0);
        step(1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, "ld");
        chk("ld_pattern", 32'(bus_a.pattern), 32'h0000_0006);
        chk("ld_z", 32'(bus_a.z), 32'd1);
        chk("ld_count", 32'(bus_a.match_count), 32'd1);

        // Gaps between bits: one match, no z in gap cycles.
        do_reset(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, s4[i], 1'b0, 4'b0000, 1'b1, 1'b0, "gap");
            step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 4'b0000, 1'b1, 1'b0, "gap");
            chk("gap_z_idle", 32'(bus_a.z), 32'd0);
        end
        chk("gap_count", 32'(bus_a.match_count), 32'd1);

        // Saturation: pattern 1111, eight 1s, then clear coincident with a hit.
        do_reset(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 4'b1111, 1'b1, 1'b0, "sat");
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, "sat");
        chk("sat_cnt_b", 32'(bus_b.match_count), 32'd3);
        chk("sat_cnt_a", 32'(bus_a.match_count), 32'd5);
        step(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1, "sat");
        chk("sat_clr_hit", 32'(bus_b.match_count), 32'd1);
        step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, "sat");
        chk("sat_clr_only", 32'(bus_b.match_count), 32'd0);

        // Reset mid-sequence: partial bits before reset never contribute.
        do_reset(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, s4[i], 1'b0, 4'b0000, 1'b1, 1'b0, "mid");
        do_reset(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, s4[i], 1'b0, 4'b0000, 1'b1, 1'b0, "mid");
        chk("mid_no_hit", 32'(bus_a.match_count), 32'd0);
        step(1'b1, s4[3], 1'b0, 4'b0000, 1'b1, 1'b0, "mid");
        chk("mid_hit", 32'(bus_a.match_count), 32'd1);

        // Randomized stream against the model.
        ov_r = 1'b1;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 9) == 0) ov_r = ~ov_r;
            if ($urandom_range(0, 79) == 0) begin
                do_reset(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end else begin
                step(($urandom_range(0, 3) != 0),
                     1'($urandom_range(0, 1)),
                     ($urandom_range(0, 24) == 0),
                     4'($urandom_range(0, 15)),
                     ov_r,
                     ($urandom_range(0, 39) == 0),
                     "rnd");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_seq_detector

// File: doc/seq_detector.md
# seq_detector

Parametrised serial bit-pattern detector for the lab FSM suite, replacing the fixed 4-bit hard-coded detector. It accepts one qualified input bit per cycle and compares a sliding history against a runtime-loadable pattern of PAT_LEN bits. Each hit produces a one-cycle registered match pulse and increments a saturating match counter. Overlapping and non-overlapping detection are selectable at runtime.

## Interface
- PAT_LEN, 4, pattern length in bits; legal range 2..32.
- CNT_W, 8, match counter width; legal range 1..32.
- RST_PATTERN, 4'b1101 zero-extended to PAT_LEN, pattern register value after reset.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; overrides every other input.
- x_valid  in  1  qualifies x; history and counters advance only when high.
- x  in  1  serial data bit; newest bit enters history bit 0.
- pattern_in  in  PAT_LEN  new pattern; bit PAT_LEN-1 is the oldest bit.
- pattern_load  in  1  loads pattern_in into the pattern register.
- overlap  in  1  1 = overlapping detection; 0 = non-overlapping.
- count_clr  in  1  clears match_count.
- z  out  1  registered match pulse.
- match_count  out  CNT_W  saturating count of matches.
- pattern  out  PAT_LEN  current pattern register.

## Operation
- State:
  - hist[PAT_LEN-1:0] shift register.
  - fill counter, 0..PAT_LEN, saturating at PAT_LEN.
  - pattern register.
  - match_count.
  - z.
- Reset values: hist=0, fill=0, pattern=RST_PATTERN, match_count=0, z=0.
- Accepted bit (x_valid=1, pattern_load=0):
  - next_hist = {hist[PAT_LEN-2:0], x}.
  - fill increments, saturating at PAT_LEN.
  - Match condition: next_hist == pattern AND (fill+1) >= PAT_LEN.
- On a match:
  - z is set to 1 at that edge.
  - match_count increments, saturating at 2^CNT_W-1 with no wrap.
- Non-overlap mode: a match resets fill to 0, so the next match needs PAT_LEN fresh bits. hist is still shifted.
- Overlap mode: fill stays at PAT_LEN, so matches may share bits.
- Any edge without a match (including x_valid=0) sets z to 0.
- x_valid=0: hist, fill and match_count hold.
- pattern_load=1:
  - pattern is set to pattern_in.
  - hist=0 and fill=0.
  - If x_valid is also high, that bit is discarded and no match is evaluated.
- count_clr together with a match on the same edge: match_count becomes 1. count_clr alone: 0.
- Changing overlap mid-stream takes effect at the next accepted bit. No history is cleared.

## Timing
- Latency: z is high in the cycle immediately after the edge that samples the completing bit. The pulse lasts exactly one cycle.
- match_count updates on that same edge.
- Back-to-back matches in overlap mode: z stays high across consecutive cycles, e.g. pattern 1111 with a continuous stream of 1s.
- Reset asserted mid-sequence: all state returns to reset values on that edge, and z is 0 in the next cycle. A partial sequence straddling reset never matches.
- Throughput: one bit per cycle with no stall and no backpressure.

## Configuration
- SEQ_DETECTOR_EARLY_Z_EN defined:
  - Adds output z_early (1 bit), a combinational Mealy output.
  - Asserted in the same cycle as the completing bit: x_valid & ~pattern_load & match condition.
  - Leads z by one cycle.
- Macro undefined: the port and its logic are absent. Behaviour is otherwise identical.

## Structure
- Shared package seq_det_pkg holds:
  - Default constants: SEQ_DET_PAT_LEN_DEF=4, SEQ_DET_CNT_W_DEF=8, SEQ_DET_RST_PATTERN=4'b1101.
  - Mode enum: {SEQ_NONOVERLAP=1'b0, SEQ_OVERLAP=1'b1}.
- One sub-module, sat_counter (parameter W): inputs clr, inc; output count.
  - Priority: clr+inc gives 1; clr gives 0; inc increments with saturation.
  - Instantiated for match_count. The fill counter stays inline.

## Test plan
- Reset default, overlap=1, stream 1,1,0,1,1,0,1 (x_valid=1): z is high after bits 4 and 7, match_count=2.
- Same stream with overlap=0: z is high only after bit 4, match_count=1.
- Load pattern 0110 at cycle 3 of stream 0,1,1,0,1,1,0 with x_valid=1 on the load cycle: that bit is dropped; history restarts; z follows only the post-load bits.
- Gaps: stream 1,1,0,1 with x_valid=0 inserted between each bit: one match, z high for exactly one cycle, no z in the gap cycles.
- CNT_W=2, overlap=1, pattern 1111, 8 consecutive 1s: match_count reaches 3 and holds. Then count_clr coincident with a match gives match_count=1.
- Reset asserted after bits 1,1,0, then bits 1,1,0,1 streamed: no match from the pre-reset bits; one match after the 4th post-reset bit. With SEQ_DETECTOR_EARLY_Z_EN, z_early is high exactly one cycle before each z.
